// File: rtl/timer_alarm_ctrl_pkg.sv
// Shared register map and field definitions for the timer alarm scheduler.
// Channel registers repeat every CH_STRIDE bytes; global registers sit at 0x80.
package timer_alarm_ctrl_pkg;

    localparam int CH_STRIDE = 16;
    localparam int CTRL_EN   = 0;

    localparam logic [3:0] OFF_CMP_LO = 4'h0;
    localparam logic [3:0] OFF_CMP_HI = 4'h4;
    localparam logic [3:0] OFF_PERIOD = 4'h8;
    localparam logic [3:0] OFF_CTRL   = 4'hC;

    localparam logic [7:0] ADDR_PENDING  = 8'h80;
    localparam logic [7:0] ADDR_ACTIVE   = 8'h84;
    localparam logic [7:0] ADDR_IRQ_MASK = 8'h88;

    typedef enum logic [1:0] {
        SEL_CMP_LO = 2'd0,
        SEL_CMP_HI = 2'd1,
        SEL_PERIOD = 2'd2,
        SEL_CTRL   = 2'd3
    } ch_reg_e;

    function automatic ch_reg_e ch_reg_sel(input logic [3:0] offset);
        return ch_reg_e'(offset[3:2]);
    endfunction

endpackage

// File: rtl/timer_alarm_ctrl_prio_enc.sv
// Lowest-index priority encoder used for the ACTIVE channel readout.
module alarm_prio_enc #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic [NUM_CH-1:0] req,
    output logic              valid,
    output logic [CH_W-1:0]   idx
);

    // Scan from the top down so the lowest requesting index is the last to win.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = CH_W'(i);
            end else begin
                idx = idx;
            end
        end
    end

endmodule

// File: rtl/timer_alarm_ctrl.sv
// Memory-mapped alarm scheduler: NUM_CH compare channels sharing one 64-bit
// comparator/adder via a free-running round-robin scan.
module timer_alarm_ctrl
    import timer_alarm_ctrl_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] us_count,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    output logic [31:0] rdata,
    output logic        irq
);

    localparam logic [3:0] CH_LIMIT = 4'(NUM_CH);

    logic [63:0]       cmp_r [NUM_CH];
    logic [31:0]       period_r [NUM_CH];
    logic [NUM_CH-1:0] en_r;
    logic [NUM_CH-1:0] pending_r;
    logic [NUM_CH-1:0] irq_mask_r;
    logic [CH_W-1:0]   scan_idx_r;
    logic [31:0]       rdata_r;
    logic              irq_r;

    logic [7:0]        addr_w_s;
    logic              ch_region_s;
    logic [CH_W-1:0]   bus_ch_s;
    ch_reg_e           bus_sel_s;
    logic [NUM_CH-1:0] wr_hit_s;
    logic [NUM_CH-1:0] w1c_s;
    logic [NUM_CH-1:0] fire_vec_s;
    logic [63:0]       scan_cmp_s;
    logic [63:0]       cmp_sum_s;
    logic              period_nz_s;
    logic              fire_s;
    logic [31:0]       rd_mux_s;
    logic              act_valid_s;
    logic [CH_W-1:0]   act_idx_s;
    logic              unused_addr_s;

    assign addr_w_s      = {addr[7:2], 2'b00};
    assign unused_addr_s = ^addr[1:0];
    assign ch_region_s   = (addr[7:4] < CH_LIMIT);
    assign bus_ch_s      = addr[4 + CH_W - 1:4];
    assign bus_sel_s     = ch_reg_sel(addr[3:0]);

    assign scan_cmp_s  = cmp_r[scan_idx_r];
    assign cmp_sum_s   = scan_cmp_s + {32'h0000_0000, period_r[scan_idx_r]};
    assign period_nz_s = |period_r[scan_idx_r];

    alarm_prio_enc #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_prio_enc (
        .req   (pending_r & irq_mask_r),
        .valid (act_valid_s),
        .idx   (act_idx_s)
    );

    // Bus decode: per-channel write hits and PENDING write-1-to-clear vector.
    always_comb begin
        wr_hit_s = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            wr_hit_s[c] = we && ch_region_s && (bus_ch_s == CH_W'(c));
        end
        if (we && (addr_w_s == ADDR_PENDING)) begin
            w1c_s = wdata[NUM_CH-1:0];
        end else begin
            w1c_s = '0;
        end
    end

    // A CPU write to the scanned channel takes precedence over its fire.
    always_comb begin
        fire_s     = en_r[scan_idx_r] && (us_count >= scan_cmp_s) && !wr_hit_s[scan_idx_r];
        fire_vec_s = '0;
        if (fire_s) begin
            fire_vec_s[scan_idx_r] = 1'b1;
        end else begin
            fire_vec_s = '0;
        end
    end

    // Read mux; reflects state before any same-cycle write.
    always_comb begin
        rd_mux_s = 32'h0000_0000;
        if (ch_region_s) begin
            case (bus_sel_s)
                SEL_CMP_LO: rd_mux_s = cmp_r[bus_ch_s][31:0];
                SEL_CMP_HI: rd_mux_s = cmp_r[bus_ch_s][63:32];
                SEL_PERIOD: rd_mux_s = period_r[bus_ch_s];
                SEL_CTRL:   rd_mux_s[CTRL_EN] = en_r[bus_ch_s];
                default:    rd_mux_s = 32'h0000_0000;
            endcase
        end else begin
            case (addr_w_s)
                ADDR_PENDING:  rd_mux_s[NUM_CH-1:0] = pending_r;
                ADDR_ACTIVE: begin
                    rd_mux_s[31]       = act_valid_s;
                    rd_mux_s[CH_W-1:0] = act_idx_s;
                end
                ADDR_IRQ_MASK: rd_mux_s[NUM_CH-1:0] = irq_mask_r;
                default:       rd_mux_s = 32'h0000_0000;
            endcase
        end
    end

    // Channel register bank: CPU writes, then periodic advance or one-shot disarm.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cmp_r[c]    <= 64'h0;
                period_r[c] <= 32'h0;
            end
            en_r <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_hit_s[c]) begin
                    case (bus_sel_s)
                        SEL_CMP_LO: begin
                            cmp_r[c][31:0] <= wdata;
                            en_r[c]        <= 1'b0;
                        end
                        SEL_CMP_HI: begin
                            cmp_r[c][63:32] <= wdata;
                            en_r[c]         <= 1'b0;
                        end
                        SEL_PERIOD: period_r[c] <= wdata;
                        SEL_CTRL:   en_r[c]     <= wdata[CTRL_EN];
                        default:    en_r[c]     <= en_r[c];
                    endcase
                end else if (fire_vec_s[c]) begin
                    if (period_nz_s) begin
                        cmp_r[c] <= cmp_sum_s;
                    end else begin
                        en_r[c] <= 1'b0;
                    end
                end else begin
                    en_r[c] <= en_r[c];
                end
            end
        end
    end

    // Global state: pending (set beats clear), mask, scan pointer, irq.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r  <= '0;
            irq_mask_r <= '0;
            scan_idx_r <= '0;
            irq_r      <= 1'b0;
        end else begin
            pending_r  <= (pending_r & ~w1c_s) | fire_vec_s;
            scan_idx_r <= scan_idx_r + CH_W'(1);
            irq_r      <= |(pending_r & irq_mask_r);
            if (we && (addr_w_s == ADDR_IRQ_MASK)) begin
                irq_mask_r <= wdata[NUM_CH-1:0];
            end else begin
                irq_mask_r <= irq_mask_r;
            end
        end
    end

    // Registered read data, held between read strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_r <= 32'h0000_0000;
        end else if (re) begin
            rdata_r <= rd_mux_s;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;
    assign irq   = irq_r;

endmodule
